// File: rtl/rocketcpu_dac128s085.sv
// Wishbone-writable driver for an 8-channel 12-bit SPI DAC (DAC128S085 class).
// Shadowed channel values are streamed as 16-bit frames, lowest dirty channel first.
module rocketcpu_dac128s085 #(
  parameter int          CLK_DIV    = 16,
  parameter logic [15:0] INIT_WORD  = 16'h9000,
  parameter int          GAP_HALVES = 2
) (
  input  logic        i_wb_clk,
  input  logic        reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_sclk,
  output logic        o_sync_n,
  output logic        o_din
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [11:0] GAP_LAST = 12'(GAP_HALVES * CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t      state;
  logic [11:0] shadow [8];
  logic [7:0]  dirty;
  logic        init_done;
  logic [15:0] shreg;
  logic [7:0]  div_cnt;
  logic [4:0]  half_cnt;
  logic [11:0] gap_cnt;

  logic [3:0]  reg_sel;
  logic        bus_req;
  logic        ch_wr;
  logic        busy;
  logic [2:0]  sel_ch;
  logic        gap_done;
  logic        start_sel;
  logic        load_frame;
  logic [15:0] load_word;
  logic [7:0]  dirty_set;
  logic [7:0]  dirty_clr;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign reg_sel     = i_wb_adr[5:2];
  assign bus_req     = i_wb_cyc & ~o_wb_ack;
  assign ch_wr       = bus_req & i_wb_we & ~reg_sel[3];
  assign busy        = (state != S_IDLE);
  assign unused_bits = ^{i_wb_adr[31:6], i_wb_adr[1:0], i_wb_dat[31:12]};

  // The final gap cycle doubles as a selection cycle, so back-to-back frames
  // are separated by exactly GAP_HALVES*CLK_DIV high cycles.
  always_comb begin
    sel_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dirty[i]) sel_ch = 3'(i);
    end
    gap_done   = (state == S_GAP) && (gap_cnt == GAP_LAST);
    start_sel  = (|dirty) && ((state == S_IDLE) || gap_done);
    load_frame = (state == S_INIT) || start_sel;
    load_word  = (state == S_INIT) ? INIT_WORD : {1'b0, sel_ch, shadow[sel_ch]};
    dirty_set  = ch_wr ? (8'd1 << reg_sel[2:0]) : 8'd0;
    dirty_clr  = start_sel ? (8'd1 << sel_ch) : 8'd0;
  end

  always_comb begin
    rd_data = 32'd0;
    if (!reg_sel[3]) begin
      rd_data = {20'd0, shadow[reg_sel[2:0]]};
    end else if (reg_sel == 4'd8) begin
      rd_data = {22'd0, init_done, busy, dirty};
    end
  end

  // Bus side: a new write's set of dirty[k] overrides a same-cycle clear.
  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
      dirty    <= 8'd0;
      for (int i = 0; i < 8; i++) shadow[i] <= 12'd0;
    end else begin
      o_wb_ack <= bus_req;
      o_wb_rdt <= bus_req ? rd_data : 32'd0;
      if (ch_wr) shadow[reg_sel[2:0]] <= i_wb_dat[11:0];
      dirty <= (dirty & ~dirty_clr) | dirty_set;
    end
  end

  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      init_done <= 1'b0;
      o_sclk    <= 1'b1;
      o_sync_n  <= 1'b1;
      o_din     <= 1'b0;
      shreg     <= 16'd0;
      div_cnt   <= 8'd0;
      half_cnt  <= 5'd0;
      gap_cnt   <= 12'd0;
    end else if (load_frame) begin
      shreg    <= load_word;
      o_din    <= load_word[15];
      o_sync_n <= 1'b0;
      o_sclk   <= 1'b1;
      div_cnt  <= 8'd0;
      half_cnt <= 5'd0;
      state    <= S_SHIFT;
    end else begin
      case (state)
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= 8'd0;
            half_cnt <= half_cnt + 5'd1;
            if (half_cnt == 5'd31) begin
              o_sclk    <= 1'b1;
              o_sync_n  <= 1'b1;
              o_din     <= 1'b0;
              gap_cnt   <= 12'd0;
              init_done <= 1'b1;
              state     <= S_GAP;
            end else begin
              o_sclk <= ~o_sclk;
              // Data advances on the SCLK rising edge, keeping it centred on the fall.
              if (!o_sclk) begin
                shreg <= {shreg[14:0], 1'b0};
                o_din <= shreg[14];
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (gap_done) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 12'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rocketcpu_dac128s085.md
Name: rocketcpu_dac128s085

Overview:
- Wishbone-writable driver for an 8-channel, 12-bit SPI DAC (DAC128S085 class). It is the output-side companion of the ADC128S102 sampler on the same rocketcpu bus.
- CPU writes channel values into shadow registers. The block streams every changed channel to the DAC as a 16-bit SPI frame, lowest pending channel first.
- After reset it sends one mode-setting frame before any channel traffic.

Parameters:
- CLK_DIV, 16, i_wb_clk cycles per SCLK half-period; legal range 1..255.
- INIT_WORD, 16'h9000, frame sent once after reset to set write-through mode.
- GAP_HALVES, 2, number of SCLK half-periods o_sync_n is held high between frames; legal range 1..15.

Ports:
- i_wb_clk  in  1  system/bus clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_wb_adr  in  32  byte address; [5:2] selects the register.
- i_wb_dat  in  32  write data.
- i_wb_we  in  1  write enable.
- i_wb_cyc  in  1  cycle/strobe.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  single-cycle acknowledge.
- o_sclk  out  1  SPI clock; idles high.
- o_sync_n  out  1  frame select, active low.
- o_din  out  1  serial data to the DAC, MSB first.

Behaviour:
- Reset (async assert, sync release). Outputs: o_sclk=1, o_sync_n=1, o_din=0, o_wb_ack=0, o_wb_rdt=0. Internal: shadow[0..7]=0, dirty=8'h00, FSM=INIT.
- Register map (adr[5:2]):
  - 0..7: channel 0..7. Write stores dat[11:0] and sets dirty[ch]. Read returns {20'b0, shadow}.
  - 8: status, read-only. Returns {22'b0, init_done, busy, dirty[7:0]}.
  - 9..15: reads return 0; writes are ignored.
- Bus handshake:
  - o_wb_ack rises the cycle after i_wb_cyc is sampled high while ack is low. It stays high for one cycle. Back-to-back cyc yields ack every second cycle.
  - Write side-effects take effect on the ack cycle. o_wb_rdt is valid on the ack cycle. The bus is never stalled by SPI activity.
- Frame format: {1'b0, ch[2:0], value[11:0]}, MSB first. The INIT frame is INIT_WORD.
- FSM states:
  - INIT: load INIT_WORD, go to SHIFT; init_done is set when that frame completes.
  - IDLE: if dirty!=0, select the lowest set bit, latch the frame from shadow, clear that dirty bit, go to SHIFT.
  - SHIFT: send the 16-bit frame.
  - GAP: hold o_sync_n=1, o_sclk=1 for GAP_HALVES*CLK_DIV cycles, then go to IDLE.
  - busy=1 in every state except IDLE.
- SHIFT timing, with T = CLK_DIV:
  - Cycle 0: o_sync_n falls, o_din = bit15, o_sclk=1.
  - Every T cycles o_sclk toggles. On each falling edge the DAC samples o_din. On each rising edge except the last, o_din advances to the next bit.
  - After the 16th falling edge plus T cycles, o_sclk returns to 1 and o_sync_n rises in the same cycle. o_sync_n is low for exactly 32*T cycles.
  - o_din is held stable for T cycles on either side of each falling edge.
- Simultaneous events:
  - A CPU write to channel k in the same cycle IDLE clears dirty[k]: the set wins, so dirty[k] stays 1, and the frame is re-sent later with the new value.
  - A write to the channel currently in flight does not alter the frame in flight; the new value is sent in a later frame.
  - Repeated writes before transmission coalesce into one frame carrying the last value.
- Reset mid-frame: o_sync_n goes high immediately (async). After release, INIT is re-sent and all shadows read 0.
- All SPI outputs are registered; there is no combinational path from bus inputs.

Test Plan:
- Release reset, CLK_DIV=2 -> one frame 0x9000 on o_din. o_sync_n is low for 64 cycles. Status reads 0x200 after the frame, 0x100 during it.
- Write 0xABC to adr 0x0C -> ack exactly 1 cycle after cyc. Frame 0x3ABC follows the INIT frame. A readback of adr 0x0C returns 0x00000ABC.
- Write ch5=0x111, ch1=0x222, ch7=0x333 back-to-back while idle -> frames sent in order 0x1222, 0x5111, 0x7333. Each gap is GAP_HALVES*CLK_DIV cycles high. Status dirty goes 0xA2 -> 0x00.
- Write ch2=0x005 then ch2=0xFFF during the ch2 frame -> first frame 0x2005, then a second frame 0x2FFF. Write ch3 twice while busy on ch0 -> a single 0x3-frame carrying the last value.
- Write ch4 in the exact cycle IDLE selects ch4 -> dirty[4] reads 1 afterwards and a second ch4 frame is sent.
- Assert reset_n low during bit 7 of a frame -> o_sync_n=1 and o_sclk=1 asynchronously. After release: a fresh 0x9000 frame and all channels read 0.
